queue: RTL and testbench



---
 rtl/queue_pkg.sv | 7 +
 rtl/queue_edge_sync.sv | 27 ++
 rtl/queue.sv | 67 ++++++
 tb/tb_queue.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/queue_pkg.sv
// Shared defaults and types for the ticket queue controller.
package queue_pkg;
  localparam int CNT_W_DEFAULT    = 8;
  localparam int CAPACITY_DEFAULT = 100;

  typedef logic [CNT_W_DEFAULT-1:0] cnt_t;
endpackage

// File: rtl/queue_edge_sync.sv
// Synchronizes an asynchronous level request and turns its rising edge into a
// single-cycle strobe.
module edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic strobe
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign strobe = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/queue.sv
// "Take a number" queue controller: issues tickets on New, calls the next
// waiting ticket on Done, and flags Full when CAPACITY clients are waiting.
module queue
  import queue_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEFAULT,
  parameter int CAPACITY    = CAPACITY_DEFAULT,
  parameter int SYNC_STAGES = 2
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             New,
  input  logic             Done,
  output logic [CNT_W-1:0] Current_Client,
  output logic [CNT_W-1:0] Total_Clients,
  output logic             Full
);

  localparam logic [CNT_W-1:0] CAP_C = CNT_W'(CAPACITY);

  logic             new_strobe;
  logic             done_strobe;
  logic             new_ok;
  logic             done_ok;
  logic [CNT_W-1:0] waiting;
  logic [CNT_W-1:0] total_nxt;
  logic [CNT_W-1:0] current_nxt;
  logic [CNT_W-1:0] waiting_nxt;

  edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_new_sync (
    .clk      (Clk),
    .rst      (Reset),
    .async_in (New),
    .strobe   (new_strobe)
  );

  edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_done_sync (
    .clk      (Clk),
    .rst      (Reset),
    .async_in (Done),
    .strobe   (done_strobe)
  );

  // Modulo difference stays correct across counter wrap.
  assign waiting = Total_Clients - Current_Client;

  always_comb begin
    done_ok     = done_strobe & (waiting != '0);
    new_ok      = new_strobe & ((waiting < CAP_C) | done_ok);
    total_nxt   = new_ok  ? Total_Clients + CNT_W'(1)  : Total_Clients;
    current_nxt = done_ok ? Current_Client + CNT_W'(1) : Current_Client;
    waiting_nxt = total_nxt - current_nxt;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      Total_Clients  <= '0;
      Current_Client <= '0;
      Full           <= 1'b0;
    end else begin
      Total_Clients  <= total_nxt;
      Current_Client <= current_nxt;
      Full           <= (waiting_nxt == CAP_C);
    end
  end

endmodule

// File: tb/tb_queue.sv
// Directed bench for the ticket queue controller with per-scenario tasks and
// hand-computed expected counter values.
module tb_queue;
  import queue_pkg::*;

  logic clk;
  logic rst;
  logic new_req;
  logic done_req;
  logic [7:0] current_client;
  logic [7:0] total_clients;
  logic full;

  int n_cmp;
  int n_fail;

  queue #(.CNT_W(8), .CAPACITY(100), .SYNC_STAGES(2)) dut (
    .Clk            (clk),
    .Reset          (rst),
    .New            (new_req),
    .Done           (done_req),
    .Current_Client (current_client),
    .Total_Clients  (total_clients),
    .Full           (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Raise the selected requests just after an edge, hold 3 edges, drop, wait
  // 3 edges, then return at the falling edge for sampling.
  task automatic pulse(input logic do_new, input logic do_done);
    @(posedge clk);
    #1;
    new_req  = do_new;
    done_req = do_done;
    repeat (3) @(posedge clk);
    #1;
    new_req  = 1'b0;
    done_req = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    new_req = 1'b0;
    done_req = 1'b0;
    #12;
    n_cmp++;
    if (total_clients !== 8'd0 || current_client !== 8'd0 || full !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_initial: total=%0d current=%0d full=%b, want 0 0 0",
               total_clients, current_client, full);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 5; i++) pulse(1'b1, 1'b0);
    for (int i = 0; i < 2; i++) pulse(1'b0, 1'b1);
    n_cmp++;
    if (total_clients !== 8'd5 || current_client !== 8'd2) begin
      n_fail++;
      $display("FAIL reset_mid_pre: total=%0d current=%0d, want 5 2",
               total_clients, current_client);
    end
    #1;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (total_clients !== 8'd0 || current_client !== 8'd0 || full !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_async: total=%0d current=%0d full=%b, want 0 0 0",
               total_clients, current_client, full);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_fill;
    logic [7:0] exp_total;
    for (int i = 1; i <= 102; i++) begin
      pulse(1'b1, 1'b0);
      exp_total = (i > 100) ? 8'd100 : 8'(i);
      n_cmp++;
      if (total_clients !== exp_total || current_client !== 8'd0 ||
          full !== (i >= 100)) begin
        n_fail++;
        $display("FAIL fill_%0d: total=%0d current=%0d full=%b, want %0d 0 %b",
                 i, total_clients, current_client, full, exp_total, (i >= 100));
      end
    end
  endtask

  task automatic test_drain;
    logic [7:0] exp_cur;
    for (int i = 1; i <= 102; i++) begin
      pulse(1'b0, 1'b1);
      exp_cur = (i > 100) ? 8'd100 : 8'(i);
      n_cmp++;
      if (current_client !== exp_cur || total_clients !== 8'd100 || full !== 1'b0) begin
        n_fail++;
        $display("FAIL drain_%0d: current=%0d total=%0d full=%b, want %0d 100 0",
                 i, current_client, total_clients, full, exp_cur);
      end
    end
  endtask

  task automatic test_held_new;
    @(posedge clk);
    #1;
    new_req = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      @(posedge clk);
      #1;
      n_cmp++;
      if (total_clients !== ((e < 3) ? 8'd100 : 8'd101)) begin
        n_fail++;
        $display("FAIL held_latency_edge%0d: total=%0d, want %0d",
                 e, total_clients, (e < 3) ? 100 : 101);
      end
    end
    repeat (47) @(posedge clk);
    #1;
    n_cmp++;
    if (total_clients !== 8'd101 || current_client !== 8'd100) begin
      n_fail++;
      $display("FAIL held_single_event: total=%0d current=%0d, want 101 100",
               total_clients, current_client);
    end
    new_req = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_simultaneous;
    for (int i = 0; i < 99; i++) pulse(1'b1, 1'b0);
    n_cmp++;
    if (total_clients !== 8'd200 || current_client !== 8'd100 || full !== 1'b1) begin
      n_fail++;
      $display("FAIL sim_prefull: total=%0d current=%0d full=%b, want 200 100 1",
               total_clients, current_client, full);
    end
    pulse(1'b1, 1'b1);
    n_cmp++;
    if (total_clients !== 8'd201 || current_client !== 8'd101 || full !== 1'b1) begin
      n_fail++;
      $display("FAIL sim_at_full: total=%0d current=%0d full=%b, want 201 101 1",
               total_clients, current_client, full);
    end
    for (int i = 0; i < 100; i++) pulse(1'b0, 1'b1);
    n_cmp++;
    if (total_clients !== 8'd201 || current_client !== 8'd201 || full !== 1'b0) begin
      n_fail++;
      $display("FAIL sim_drained: total=%0d current=%0d full=%b, want 201 201 0",
               total_clients, current_client, full);
    end
    pulse(1'b1, 1'b1);
    n_cmp++;
    if (total_clients !== 8'd202 || current_client !== 8'd201 || full !== 1'b0) begin
      n_fail++;
      $display("FAIL sim_at_empty: total=%0d current=%0d full=%b, want 202 201 0",
               total_clients, current_client, full);
    end
    pulse(1'b0, 1'b1);
    n_cmp++;
    if (current_client !== 8'd202) begin
      n_fail++;
      $display("FAIL sim_final_done: current=%0d, want 202", current_client);
    end
  endtask

  task automatic test_wrap;
    cnt_t exp_total;
    cnt_t exp_cur;
    exp_total = 8'd202;
    exp_cur   = 8'd202;
    for (int i = 0; i < 300; i++) begin
      pulse(1'b1, 1'b0);
      exp_total = exp_total + 8'd1;
      n_cmp++;
      if (total_clients !== exp_total || current_client !== exp_cur || full !== 1'b0) begin
        n_fail++;
        $display("FAIL wrap_new_%0d: total=%0d current=%0d full=%b, want %0d %0d 0",
                 i, total_clients, current_client, full, exp_total, exp_cur);
      end
      pulse(1'b0, 1'b1);
      exp_cur = exp_cur + 8'd1;
      n_cmp++;
      if (total_clients !== exp_total || current_client !== exp_cur || full !== 1'b0) begin
        n_fail++;
        $display("FAIL wrap_done_%0d: total=%0d current=%0d full=%b, want %0d %0d 0",
                 i, total_clients, current_client, full, exp_total, exp_cur);
      end
    end
    n_cmp++;
    if (total_clients !== 8'd246 || current_client !== 8'd246) begin
      n_fail++;
      $display("FAIL wrap_end: total=%0d current=%0d, want 246 246",
               total_clients, current_client);
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    test_reset();
    test_reset_mid();
    test_fill();
    test_drain();
    test_held_new();
    test_simultaneous();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
